// File: rtl/clock_group_reset_sequencer_pkg.sv
// Shared types and helpers for the clock-group reset sequencer.
package clock_group_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } seq_state_e;

  // Bit width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/clock_group_reset_sequencer_lsb_onehot.sv
// Isolates the lowest set bit of a vector and flags whether it is the only one.
module lsb_onehot #(
  parameter int N = 6
) (
  input  logic [N-1:0] v_i,
  output logic [N-1:0] lsb_o,
  output logic         last_o
);

  // Two's-complement trick: v & -v keeps only the lowest set bit; an empty
  // vector also reports last so the sequencer can never stall in RELEASE.
  always_comb begin
    lsb_o  = v_i & (-v_i);
    last_o = (v_i == lsb_o);
  end

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Per-group reset sequencer: asserts on request, holds, then releases groups
// one at a time in ascending index order with a fixed stagger.
module clock_group_reset_sequencer
  import clock_group_pkg::*;
#(
  parameter int N_GROUPS    = 6,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_GROUPS-1:0] in_reset,
  output logic [N_GROUPS-1:0] out_reset,
  output logic                busy,
  output logic                seq_done,
  output seq_state_e          dbg_state_o
);

  localparam int HW = clog2_min1(HOLD_CYCLES + 1);
  localparam int SW = clog2_min1(STAGGER + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STG_LOAD  = SW'(STAGGER - 1);

  seq_state_e          state_q, state_d;
  logic [N_GROUPS-1:0] out_reset_q, out_reset_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]       stg_cnt_q, stg_cnt_d;
  logic                seq_done_q, seq_done_d;
  logic [N_GROUPS-1:0] lsb;
  logic                last_bit;
  logic                req;

  lsb_onehot #(.N(N_GROUPS)) u_lsb (
    .v_i    (out_reset_q),
    .lsb_o  (lsb),
    .last_o (last_bit)
  );

  // Next-state logic: requests always OR into the pending set, so a group
  // whose request is high can never see its reset drop.
  always_comb begin
    req         = |in_reset;
    state_d     = state_q;
    out_reset_d = out_reset_q | in_reset;
    hold_cnt_d  = hold_cnt_q;
    stg_cnt_d   = stg_cnt_q;
    seq_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = ASSERT;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ASSERT: begin
        if (req) begin
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end else begin
          state_d   = RELEASE;
          stg_cnt_d = '0;
        end
      end
      RELEASE: begin
        if (req) begin
          // A new request wins over a release scheduled for this cycle.
          state_d    = ASSERT;
          hold_cnt_d = HOLD_LOAD;
        end else if (stg_cnt_q == '0) begin
          out_reset_d = out_reset_q & ~lsb;
          stg_cnt_d   = STG_LOAD;
          if (last_bit) begin
            state_d    = IDLE;
            seq_done_d = 1'b1;
          end
        end else begin
          stg_cnt_d = stg_cnt_q - SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous full-restart reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ASSERT;
      out_reset_q <= '1;
      hold_cnt_q  <= HOLD_LOAD;
      stg_cnt_q   <= '0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_reset_q <= out_reset_d;
      hold_cnt_q  <= hold_cnt_d;
      stg_cnt_q   <= stg_cnt_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign out_reset   = out_reset_q;
  assign seq_done    = seq_done_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for the clock-group reset sequencer: directed timing scenarios on the
// default configuration, a small fast configuration, and random request traffic.
module tb_clock_group_reset_sequencer;
  import clock_group_pkg::*;

  localparam int N = 6;
  localparam int H = 16;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst  = 1'b1;
  logic       rst2 = 1'b1;
  logic [5:0] in1  = '0;
  logic [2:0] in2  = '0;
  logic [5:0] out1;
  logic [2:0] out2;
  logic       busy1, busy2, done1, done2;
  seq_state_e st1, st2;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] exp_q[$];
  logic [4:0] exp2_q[$];

  clock_group_reset_sequencer #(.N_GROUPS(N), .HOLD_CYCLES(H), .STAGGER(S)) dut (
    .clock(clock), .reset(rst), .in_reset(in1), .out_reset(out1),
    .busy(busy1), .seq_done(done1), .dbg_state_o(st1)
  );

  clock_group_reset_sequencer #(.N_GROUPS(3), .HOLD_CYCLES(1), .STAGGER(1)) dut_small (
    .clock(clock), .reset(rst2), .in_reset(in2), .out_reset(out2),
    .busy(busy2), .seq_done(done2), .dbg_state_o(st2)
  );

  // ---------------- drivers ----------------
  // Each cycle starts 1ns after a rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in1 = '0;
    repeat (5) tick();
    rst = 1'b0;
  endtask

  task automatic apply_reset_small();
    rst2 = 1'b1;
    in2  = '0;
    repeat (5) tick();
    rst2 = 1'b0;
  endtask

  // Expected {seq_done, busy, out_reset} for cycle c of an undisturbed sequence.
  function automatic logic [7:0] exp_fresh(input int c);
    logic [5:0] o;
    for (int i = 0; i < N; i++) o[i] = (c < H + 1 + S * i);
    return {(c == H + 1 + S * (N - 1)), (c < H + 1 + S * (N - 1)), o};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] got;
    apply_reset();
    @(negedge clock);
    got = {done1, busy1, out1};
    n_checks++;
    if (got !== 8'b0111_1111) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b expected %b", got, 8'b0111_1111);
    end
    n_checks++;
    if (st1 !== ASSERT) begin
      n_fails++;
      $display("FAIL reset_state: got %0d expected %0d", st1, ASSERT);
    end
    tick();
  endtask

  task automatic test_power_on_sequence();
    logic [7:0] got, exp;
    for (int c = 1; c <= 40; c++) exp_q.push_back(exp_fresh(c));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      got = {done1, busy1, out1};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL power_on_seq cycle %0d: got %b expected %b", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_single_group();
    logic [7:0] got, exp;
    logic       pend;
    for (int k = 0; k <= 24; k++) begin
      pend = (k >= 1 && k <= 19);
      exp_q.push_back({(k == 20), pend, 3'b000, pend, 2'b00});
    end
    for (int k = 0; k <= 24; k++) begin
      in1 = (k < 3) ? 6'b000100 : 6'b000000;
      @(negedge clock);
      got = {done1, busy1, out1};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL single_group k=%0d: got %b expected %b", k, got, exp);
      end
      tick();
    end
    in1 = '0;
  endtask

  task automatic test_rerequest();
    logic [7:0] got, exp;
    logic [5:0] o;
    apply_reset();
    for (int c = 0; c <= 60; c++) begin
      o[0] = (c < 17) || (c >= 23 && c < 40);
      o[1] = (c < 21);
      for (int j = 2; j < N; j++) o[j] = (c < 40 + S * (j - 1));
      exp_q.push_back({(c == 56), (c < 56), o});
    end
    for (int c = 0; c <= 60; c++) begin
      in1 = (c == 22) ? 6'b000001 : 6'b000000;
      @(negedge clock);
      got = {done1, busy1, out1};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL rerequest cycle %0d: got %b expected %b", c, got, exp);
      end
      tick();
    end
    in1 = '0;
  endtask

  task automatic test_reset_mid_sequence();
    logic [7:0] got, exp;
    apply_reset();
    for (int c = 0; c <= 26; c++) exp_q.push_back(exp_fresh(c));
    for (int c = 0; c <= 26; c++) begin
      rst = (c == 26);
      @(negedge clock);
      got = {done1, busy1, out1};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", c, got, exp);
      end
      tick();
    end
    rst = 1'b0;
    for (int c = 0; c <= 40; c++) exp_q.push_back(exp_fresh(c));
    for (int c = 0; c <= 40; c++) begin
      @(negedge clock);
      got = {done1, busy1, out1};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL reset_mid_restart cycle %0d: got %b expected %b", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_small_config();
    logic [4:0] got, exp;
    logic [2:0] o;
    apply_reset_small();
    for (int c = 0; c <= 5; c++) begin
      for (int i = 0; i < 3; i++) o[i] = (c < 2 + i);
      exp2_q.push_back({(c == 4), (c < 4), o});
    end
    for (int c = 0; c <= 5; c++) begin
      @(negedge clock);
      got = {done2, busy2, out2};
      exp = exp2_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL small_power_on cycle %0d: got %b expected %b", c, got, exp);
      end
      tick();
    end
    for (int k = 0; k <= 6; k++) begin
      o = (k == 1 || k == 2) ? 3'b101 : ((k == 3) ? 3'b100 : 3'b000);
      exp2_q.push_back({(k == 4), (k >= 1 && k <= 3), o});
    end
    for (int k = 0; k <= 6; k++) begin
      in2 = (k == 0) ? 3'b101 : 3'b000;
      @(negedge clock);
      got = {done2, busy2, out2};
      exp = exp2_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL small_skip k=%0d: got %b expected %b", k, got, exp);
      end
      tick();
    end
    in2 = '0;
  endtask

  task automatic test_random_traffic();
    logic [5:0] pat, m, prev_out, fell;
    int         burst;
    int         last_rel;
    int         idx;
    burst    = 0;
    pat      = '0;
    last_rel = -1;
    prev_out = out1;
    for (int c = 0; c < 10000; c++) begin
      if (burst > 0) begin
        burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        pat   = 6'($urandom_range(1, 63));
        burst = $urandom_range(0, 2);
      end else begin
        pat = '0;
      end
      in1 = pat;
      exp_q.push_back({2'b00, pat});
      @(negedge clock);
      if (c > 0) begin
        m    = exp_q.pop_front()[5:0];
        fell = prev_out & ~out1;
        n_checks++;
        if ((out1 & m) !== m) begin
          n_fails++;
          $display("FAIL rand_held cycle %0d: got %b required mask %b", c, out1, m);
        end
        n_checks++;
        if (!$onehot0(fell) || (m != 0 && fell != 0)) begin
          n_fails++;
          $display("FAIL rand_release_shape cycle %0d: fell %b request %b", c, fell, m);
        end
        if (fell != 0) begin
          idx = 0;
          for (int i = N - 1; i >= 0; i--) if (fell[i]) idx = i;
          n_checks++;
          if (idx <= last_rel) begin
            n_fails++;
            $display("FAIL rand_order cycle %0d: released %0d after %0d", c, idx, last_rel);
          end
          last_rel = idx;
        end
        if (done1) begin
          n_checks++;
          if (out1 !== 6'b000000 || fell == 0) begin
            n_fails++;
            $display("FAIL rand_seq_done cycle %0d: out %b fell %b expected out 000000 with a release", c, out1, fell);
          end
          last_rel = -1;
        end
        if (m != 0) last_rel = -1;
      end
      prev_out = out1;
      tick();
    end
    in1 = '0;
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_power_on_sequence();
    test_single_group();
    test_rerequest();
    test_reset_mid_sequence();
    test_small_config();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
